// File: rtl/rgb_effect_pkg.sv
// Shared encodings and colour helpers for the RGB effect generator.
package rgb_effect_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'd0,
        MODE_BREATHE = 2'd1,
        MODE_RAINBOW = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int HUE_MAX_DEF = 767;

    // Channel fields of the {R,G,B} word
    localparam int CH_W  = 8;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    // (c*(lvl+1))>>8 so that full level reproduces c exactly and level 0 is black
    function automatic logic [7:0] scale8(logic [7:0] c, logic [7:0] lvl);
        logic [15:0] p;
        p = 16'(c) * 16'(lvl) + 16'(c);
        return p[15:8];
    endfunction

    function automatic logic [23:0] wheel(logic [9:0] hue);
        logic [7:0] f;
        f = hue[7:0];
        case (hue[9:8])
            2'd1:    return {8'h00, ~f, f};
            2'd2:    return {f, 8'h00, ~f};
            default: return {~f, f, 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/rgb_effect_gen_if.sv
// Control and colour-word bundle between the effect generator and its user.
interface rgb_effect_gen_if;
    logic        enable_i;
    logic [1:0]  mode_i;
    logic [23:0] base_rgb_i;
    logic [7:0]  speed_i;
    logic [23:0] RGB_Data;
    logic        rgb_update_o;

    modport master (
        output enable_i, mode_i, base_rgb_i, speed_i,
        input  RGB_Data, rgb_update_o
    );

    modport slave (
        input  enable_i, mode_i, base_rgb_i, speed_i,
        output RGB_Data, rgb_update_o
    );
endinterface

// File: rtl/effect_tick_div.sv
// Tick prescaler plus speed-programmable step counter; emits a one-cycle step pulse.
module effect_tick_div #(
    parameter int DIV = 100_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       hold_i,
    input  logic [7:0] speed_i,
    output logic       step_o
);
    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          tick;

    assign tick = (presc_q == LAST);

    // >= rather than == so a speed lowered below the running count steps at once
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        step_o  = tick && !hold_i && (cnt_q >= speed_i);
        cnt_d   = cnt_q;
        if (clr_i || step_o)
            cnt_d = '0;
        else if (tick && !hold_i)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/rgb_effect_gen.sv
// Effect state, colour math and registered colour word for the SK6805 driver.
module rgb_effect_gen
    import rgb_effect_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int STEP_HZ = 1000,
    parameter int HUE_MAX = HUE_MAX_DEF
) (
    input logic              clk_100MHz,
    input logic              Rst,
    rgb_effect_gen_if.slave  bus
);
    localparam logic [9:0] HUE_LAST = 10'(HUE_MAX);

    logic        step, mode_chg;
    mode_e       mode_q;
    logic [9:0]  hue_q, hue_d;
    logic [7:0]  lvl_q, lvl_d;
    dir_e        dir_q, dir_d;
    logic        blink_q, blink_d;
    logic        en_q;
    logic [23:0] base_q;
    logic [23:0] color_d, rgb_q;
    logic        upd_q;

    assign mode_chg = (bus.mode_i != mode_q);

    effect_tick_div #(.DIV(CLK_HZ / STEP_HZ)) u_tick (
        .clk_i   (clk_100MHz),
        .rst_ni  (Rst),
        .clr_i   (mode_chg),
        .hold_i  (!bus.enable_i),
        .speed_i (bus.speed_i),
        .step_o  (step)
    );

    // Mode change wins over a coincident step
    always_comb begin
        hue_d   = hue_q;
        lvl_d   = lvl_q;
        dir_d   = dir_q;
        blink_d = blink_q;
        if (mode_chg) begin
            hue_d   = '0;
            lvl_d   = '0;
            dir_d   = DIR_UP;
            blink_d = 1'b1;
        end else if (step) begin
            case (mode_q)
                MODE_BREATHE: begin
                    if (dir_q == DIR_UP) begin
                        if (lvl_q == 8'hFF) dir_d = DIR_DOWN;
                        else                lvl_d = lvl_q + 8'd1;
                    end else begin
                        if (lvl_q == 8'h00) dir_d = DIR_UP;
                        else                lvl_d = lvl_q - 8'd1;
                    end
                end
                MODE_RAINBOW: hue_d   = (hue_q >= HUE_LAST) ? '0 : hue_q + 10'd1;
                MODE_BLINK:   blink_d = !blink_q;
                default: ;
            endcase
        end
    end

    // Base and enable are registered so they line up with the effect state
    always_comb begin
        color_d = '0;
        if (en_q) begin
            case (mode_q)
                MODE_STATIC:  color_d = base_q;
                MODE_BREATHE: begin
                    color_d[R_LSB +: CH_W] = scale8(base_q[R_LSB +: CH_W], lvl_q);
                    color_d[G_LSB +: CH_W] = scale8(base_q[G_LSB +: CH_W], lvl_q);
                    color_d[B_LSB +: CH_W] = scale8(base_q[B_LSB +: CH_W], lvl_q);
                end
                MODE_RAINBOW: color_d = wheel(hue_q);
                MODE_BLINK:   color_d = blink_q ? base_q : '0;
                default:      color_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge Rst) begin
        if (!Rst) begin
            mode_q  <= MODE_STATIC;
            hue_q   <= '0;
            lvl_q   <= '0;
            dir_q   <= DIR_UP;
            blink_q <= 1'b1;
            en_q    <= 1'b0;
            base_q  <= '0;
            rgb_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            mode_q  <= mode_e'(bus.mode_i);
            hue_q   <= hue_d;
            lvl_q   <= lvl_d;
            dir_q   <= dir_d;
            blink_q <= blink_d;
            en_q    <= bus.enable_i;
            base_q  <= bus.base_rgb_i;
            rgb_q   <= color_d;
            upd_q   <= (color_d != rgb_q);
        end
    end

    assign bus.RGB_Data     = rgb_q;
    assign bus.rgb_update_o = upd_q;
endmodule
